// File: rtl/ddr3_cmd_responder.sv
// Device-side DDR3-style command responder: decodes the command bus, tracks open rows per bank,
// stores write data and returns read data on DQ after CL cycles, flagging protocol violations.
module ddr3_cmd_responder #(
  parameter int CL      = 5,
  parameter int CWL     = 4,
  parameter int ROW_LSB = 4,
  parameter int COL_LSB = 4,
  parameter int TRFC    = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CS,
  input  logic        RAS,
  input  logic        CAS,
  input  logic        WE,
  input  logic [2:0]  BA,
  input  logic [14:0] Addr,
  input  logic        LDM,
  input  logic        UDM,
  inout  wire  [15:0] DQ,
  output logic [14:0] mode_reg,
  output logic [7:0]  bank_open,
  output logic        ready,
  output logic        err,
  output logic [1:0]  o_fsm_state
);

  localparam int IW    = 3 + ROW_LSB + COL_LSB;
  localparam int DEPTH = 1 << IW;
  localparam int TW    = (TRFC > 1) ? $clog2(TRFC) : 1;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_REFRESH = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    C_MRS   = 3'b000,
    C_REF   = 3'b001,
    C_PRE   = 3'b010,
    C_ACT   = 3'b011,
    C_WRITE = 3'b100,
    C_READ  = 3'b101,
    C_ZQCL  = 3'b110,
    C_NOP   = 3'b111
  } cmd_t;

  state_t              r_state;
  logic [TW-1:0]       r_cnt;
  logic [ROW_LSB-1:0]  r_row [8];
  logic [15:0]         r_mem [DEPTH];
  logic [CL-1:0]       r_rd_v;
  logic [IW-1:0]       r_rd_idx [CL];
  logic [CWL-1:0]      r_wr_v;
  logic [IW-1:0]       r_wr_idx [CWL];
  logic                r_dq_en;
  logic [15:0]         r_dq_out;

  cmd_t                w_cmd;
  logic                w_bank_hit;
  logic [IW-1:0]       w_idx;
  logic                w_rd_go;
  logic                w_wr_go;
  logic                w_collide;

  assign w_cmd      = CS ? C_NOP : cmd_t'({RAS, CAS, WE});
  assign w_bank_hit = bank_open[BA];
  assign w_idx      = {BA, r_row[BA], Addr[COL_LSB-1:0]};
  assign w_rd_go    = (r_state == ST_IDLE) && (w_cmd == C_READ) && w_bank_hit;
  assign w_wr_go    = (r_state == ST_IDLE) && (w_cmd == C_WRITE) && w_bank_hit;
  // Read would drive DQ during the very cycle a write samples it on the following edge.
  assign w_collide  = r_rd_v[CL-1] && r_wr_v[CWL-2];

  assign DQ          = r_dq_en ? r_dq_out : 16'bz;
  assign o_fsm_state = r_state;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= ST_INIT;
      r_cnt     <= '0;
      mode_reg  <= '0;
      bank_open <= '0;
      ready     <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < 8; i++) r_row[i] <= '0;
    end else begin
      if (w_collide) err <= 1'b1;
      case (r_state)
        ST_INIT: begin
          case (w_cmd)
            C_MRS: begin
              mode_reg <= Addr;
              r_state  <= ST_IDLE;
              ready    <= 1'b1;
            end
            C_ZQCL, C_NOP: ;
            default: err <= 1'b1;
          endcase
        end
        ST_IDLE: begin
          case (w_cmd)
            C_ACT: begin
              if (w_bank_hit) begin
                err <= 1'b1;
              end else begin
                r_row[BA]     <= Addr[ROW_LSB-1:0];
                bank_open[BA] <= 1'b1;
              end
            end
            C_READ, C_WRITE: begin
              if (!w_bank_hit) err <= 1'b1;
              else if (Addr[10]) bank_open[BA] <= 1'b0;
            end
            C_PRE: begin
              if (Addr[10]) bank_open <= '0;
              else bank_open[BA] <= 1'b0;
            end
            C_REF: begin
              if (|bank_open) err <= 1'b1;
              r_state <= ST_REFRESH;
              r_cnt   <= TW'(TRFC - 1);
              ready   <= 1'b0;
            end
            C_MRS: begin
              if (|bank_open) err <= 1'b1;
              mode_reg <= Addr;
            end
            default: ;
          endcase
        end
        ST_REFRESH: begin
          if (w_cmd != C_NOP) err <= 1'b1;
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_rd_v  <= '0;
      r_wr_v  <= '0;
      r_dq_en <= 1'b0;
    end else begin
      for (int i = CL - 1; i > 0; i--) r_rd_v[i] <= r_rd_v[i-1];
      r_rd_v[0] <= w_rd_go;
      for (int i = CWL - 1; i > 0; i--) r_wr_v[i] <= r_wr_v[i-1];
      r_wr_v[0] <= w_wr_go;
      r_dq_en   <= r_rd_v[CL-1] && !w_collide;
    end
  end

  // Index pipelines and storage carry no reset; validity lives in r_rd_v / r_wr_v.
  always_ff @(posedge CLK) begin
    for (int i = CL - 1; i > 0; i--) r_rd_idx[i] <= r_rd_idx[i-1];
    r_rd_idx[0] <= w_idx;
    for (int i = CWL - 1; i > 0; i--) r_wr_idx[i] <= r_wr_idx[i-1];
    r_wr_idx[0] <= w_idx;
    if (!RESET && r_rd_v[CL-1]) r_dq_out <= r_mem[r_rd_idx[CL-1]];
    if (!RESET && r_wr_v[CWL-1]) begin
      if (!LDM) r_mem[r_wr_idx[CWL-1]][7:0]  <= DQ[7:0];
      if (!UDM) r_mem[r_wr_idx[CWL-1]][15:8] <= DQ[15:8];
    end
  end

endmodule

// File: tb/tb_ddr3_cmd_responder.sv
// Directed bench for ddr3_cmd_responder; DQ is pulled high so an undriven bus reads 16'hFFFF.
module tb_ddr3_cmd_responder;

  localparam int CL   = 5;
  localparam int CWL  = 4;
  localparam int TRFC = 8;

  localparam logic [2:0] K_MRS   = 3'b000;
  localparam logic [2:0] K_REF   = 3'b001;
  localparam logic [2:0] K_PRE   = 3'b010;
  localparam logic [2:0] K_ACT   = 3'b011;
  localparam logic [2:0] K_WRITE = 3'b100;
  localparam logic [2:0] K_READ  = 3'b101;

  localparam logic [15:0] UNDRIVEN = 16'hFFFF;

  logic        clk;
  logic        rst;
  logic        cs, ras, cas, we;
  logic [2:0]  ba;
  logic [14:0] addr;
  logic        ldm, udm;
  tri1  [15:0] dq;
  logic [15:0] tb_dq;
  logic        tb_oe;
  logic [14:0] mode_reg;
  logic [7:0]  bank_open;
  logic        ready;
  logic        err;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;

  assign dq = tb_oe ? tb_dq : 16'hzzzz;

  ddr3_cmd_responder #(
    .CL(CL), .CWL(CWL), .ROW_LSB(4), .COL_LSB(4), .TRFC(TRFC)
  ) dut (
    .CLK(clk), .RESET(rst), .CS(cs), .RAS(ras), .CAS(cas), .WE(we),
    .BA(ba), .Addr(addr), .LDM(ldm), .UDM(udm), .DQ(dq),
    .mode_reg(mode_reg), .bank_open(bank_open), .ready(ready), .err(err),
    .o_fsm_state(fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [2:0] c, input logic [2:0] b, input logic [14:0] a);
    cs = 1'b0;
    {ras, cas, we} = c;
    ba = b;
    addr = a;
    tick();
    cs = 1'b1;
    {ras, cas, we} = 3'b111;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic write_data(input logic [2:0] b, input logic [14:0] a, input logic [15:0] d,
                            input logic l, input logic u);
    cmd(K_WRITE, b, a);
    repeat (CWL - 1) tick();
    tb_oe = 1'b1;
    tb_dq = d;
    ldm = l;
    udm = u;
    tick();
    tb_oe = 1'b0;
    ldm = 1'b0;
    udm = 1'b0;
  endtask

  // Data must appear exactly CL cycles after the READ edge, for one cycle only.
  task automatic read_expect(input string tag, input logic [2:0] b, input logic [14:0] a,
                             input logic [15:0] exp);
    cmd(K_READ, b, a);
    check({tag, "_pre0"}, dq, UNDRIVEN);
    for (int k = 1; k < CL; k++) begin
      tick();
      check({tag, "_pre"}, dq, UNDRIVEN);
    end
    tick();
    check({tag, "_data"}, dq, exp);
    tick();
    check({tag, "_post"}, dq, UNDRIVEN);
  endtask

  initial begin
    rst = 1'b1;
    cs = 1'b1;
    {ras, cas, we} = 3'b111;
    ba = '0;
    addr = '0;
    ldm = 1'b0;
    udm = 1'b0;
    tb_dq = '0;
    tb_oe = 1'b0;

    do_reset();
    check("rst_mode", {1'b0, mode_reg}, 16'h0000);
    check("rst_bank", {8'h00, bank_open}, 16'h0000);
    check("rst_ready", {15'd0, ready}, 16'h0000);
    check("rst_err", {15'd0, err}, 16'h0000);
    check("rst_state", {14'd0, fsm_state}, 16'h0000);
    check("rst_dq", dq, UNDRIVEN);

    cmd(K_READ, 3'd0, 15'h0000);
    check("init_read_err", {15'd0, err}, 16'h0001);
    check("init_read_ready", {15'd0, ready}, 16'h0000);

    do_reset();
    check("err_cleared", {15'd0, err}, 16'h0000);
    cmd(K_MRS, 3'd0, 15'h0123);
    check("mrs_mode", {1'b0, mode_reg}, 16'h0123);
    check("mrs_ready", {15'd0, ready}, 16'h0001);
    check("mrs_state", {14'd0, fsm_state}, 16'h0001);
    check("mrs_err", {15'd0, err}, 16'h0000);

    cmd(K_ACT, 3'd3, 15'd5);
    check("act3_bank", {8'h00, bank_open}, 16'h0008);
    write_data(3'd3, 15'd7, 16'hF00F, 1'b0, 1'b0);
    cmd(K_PRE, 3'd3, 15'h0000);
    check("pre3_bank", {8'h00, bank_open}, 16'h0000);
    cmd(K_ACT, 3'd3, 15'd5);
    check("react3_bank", {8'h00, bank_open}, 16'h0008);
    read_expect("rd_f00f", 3'd3, 15'd7, 16'hF00F);

    write_data(3'd3, 15'd7, 16'hA5A5, 1'b0, 1'b1);
    read_expect("rd_mask", 3'd3, 15'd7, 16'hF0A5);
    check("mask_err", {15'd0, err}, 16'h0000);

    read_expect("rd_closed", 3'd2, 15'd7, UNDRIVEN);
    check("closed_err", {15'd0, err}, 16'h0001);
    check("closed_bank", {8'h00, bank_open}, 16'h0008);

    do_reset();
    check("rst2_bank", {8'h00, bank_open}, 16'h0000);
    check("rst2_err", {15'd0, err}, 16'h0000);
    cmd(K_MRS, 3'd0, 15'h0042);
    check("mrs2_ready", {15'd0, ready}, 16'h0001);
    cmd(K_ACT, 3'd1, 15'd2);
    cmd(K_ACT, 3'd3, 15'd5);
    check("two_open", {8'h00, bank_open}, 16'h000A);
    cmd(K_PRE, 3'd0, 15'h0400);
    check("pre_all", {8'h00, bank_open}, 16'h0000);
    check("pre_all_err", {15'd0, err}, 16'h0000);

    cmd(K_REF, 3'd0, 15'h0000);
    check("ref_ready0", {15'd0, ready}, 16'h0000);
    check("ref_state", {14'd0, fsm_state}, 16'h0002);
    check("ref_err", {15'd0, err}, 16'h0000);
    cmd(K_ACT, 3'd1, 15'd9);
    check("ref_act_err", {15'd0, err}, 16'h0001);
    check("ref_act_bank", {8'h00, bank_open}, 16'h0000);
    check("ref_ready1", {15'd0, ready}, 16'h0000);
    for (int p = 2; p < TRFC; p++) begin
      tick();
      check("ref_busy", {15'd0, ready}, 16'h0000);
    end
    tick();
    check("ref_done_ready", {15'd0, ready}, 16'h0001);
    check("ref_done_state", {14'd0, fsm_state}, 16'h0001);

    do_reset();
    cmd(K_MRS, 3'd0, 15'h0000);
    cmd(K_ACT, 3'd3, 15'd5);
    read_expect("rd_ap", 3'd3, 15'h0407, 16'hF0A5);
    check("ap_bank", {8'h00, bank_open}, 16'h0000);
    check("ap_err", {15'd0, err}, 16'h0000);

    cmd(K_ACT, 3'd3, 15'd5);
    cmd(K_READ, 3'd3, 15'd7);
    repeat (CL - 3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = CL - 1; p <= CL + 2; p++) begin
      tick();
      check("rst_mid_dq", dq, UNDRIVEN);
    end
    check("rst_mid_bank", {8'h00, bank_open}, 16'h0000);
    check("rst_mid_ready", {15'd0, ready}, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
